test_result_monitor: RTL and testbench

//  Bus-snooping end-of-test monitor for the SuiteA regression benches.
//  - Sits downstream of the core's memory port, beside top.mem. Watches CPU writes.
//  - Captures the value written to the result location.
//  - Declares pass, fail or timeout once bus writes stop. This replaces fixed-delay

---
 rtl/test_result_monitor.sv | 130 +++++++++++++
 tb/tb_test_result_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_result_monitor.sv
// Bus-snooping end-of-test monitor: captures the byte written to RESULT_ADDR and
// declares pass, fail or timeout once CPU writes go quiet.
module test_result_monitor #(
    parameter logic [15:0] RESULT_ADDR    = 16'h0040,
    parameter logic [7:0]  EXPECTED       = 8'h33,
    parameter int unsigned QUIET_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CW             = 16
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data,
    input  logic        memwrite,
    output logic [7:0]  result,
    output logic [7:0]  write_count,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      result_q, result_d;
    logic [7:0]      write_count_q, write_count_d;
    logic [CW-1:0]   quiet_cnt_q, quiet_cnt_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic            timeout_q, timeout_d;

    logic            hit;
    logic            active;
    logic            verdict;

    always_ff @(posedge ph2) begin
        if (reset) begin
            state_q       <= ST_RUN;
            result_q      <= 8'h00;
            write_count_q <= 8'h00;
            quiet_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            result_q      <= result_d;
            write_count_q <= write_count_d;
            quiet_cnt_q   <= quiet_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        write_count_d = write_count_q;
        quiet_cnt_d   = quiet_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        verdict       = 1'b0;

        hit    = memwrite && (address == RESULT_ADDR);
        active = (state_q == ST_RUN) || (state_q == ST_SETTLE);

        // Capture and timeout counting only while the test is still live
        if (active) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
            if (hit) begin
                result_d = data;
                if (write_count_q != 8'hFF) begin
                    write_count_d = write_count_q + 8'd1;
                end
            end
        end

        case (state_q)
            ST_RUN: begin
                if (hit) begin
                    state_d     = ST_SETTLE;
                    quiet_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (memwrite) begin
                    quiet_cnt_d = '0;
                end else if (quiet_cnt_q == CW'(QUIET_CYCLES - 1)) begin
                    verdict = 1'b1;
                    state_d = (result_q == EXPECTED) ? ST_PASS : ST_FAIL;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + CW'(1);
                end
            end
            default: begin
            end
        endcase

        // A verdict in the same cycle wins over the timeout
        if (active && !verdict && (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
            state_d = ST_TIMEOUT;
        end

        done_d    = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
        pass_d    = (state_q == ST_PASS);
        fail_d    = (state_q == ST_FAIL);
        timeout_d = (state_q == ST_TIMEOUT);
    end

    assign result      = result_q;
    assign write_count = write_count_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Scoreboard bench for test_result_monitor: expected verdicts are queued with the
// stimulus and compared when done rises.
module tb_test_result_monitor;

    typedef struct {
        int         lat;
        logic       p;
        logic       f;
        logic       t;
        logic [7:0] res;
        logic [7:0] wc;
    } exp_t;

    logic        ph2 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data = 8'h00;
    logic        memwrite = 1'b0;
    logic [7:0]  result;
    logic [7:0]  write_count;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;

    exp_t sb_q[$];
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   n;

    test_result_monitor dut (
        .ph2         (ph2),
        .reset       (reset),
        .address     (address),
        .data        (data),
        .memwrite    (memwrite),
        .result      (result),
        .write_count (write_count),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout)
    );

    always #5 ph2 = ~ph2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ph2);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input int cycles);
        reset    = 1'b1;
        memwrite = 1'b0;
        repeat (cycles) tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        address  = a;
        data     = d;
        memwrite = 1'b1;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        while (!done && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    // Background traffic to one address every 10 cycles until done or a cycle bound
    task automatic bg_writes(input logic [15:0] a, output int at_cyc);
        while (!done && cyc < 1200) begin
            address  = a;
            data     = 8'hAA;
            memwrite = (cyc % 10 == 0);
            tick();
            memwrite = 1'b0;
        end
        at_cyc = cyc;
    endtask

    task automatic push_exp(input int lat, input logic p, input logic f, input logic t,
                            input logic [7:0] res, input logic [7:0] wc);
        exp_t e;
        e.lat = lat;
        e.p   = p;
        e.f   = f;
        e.t   = t;
        e.res = res;
        e.wc  = wc;
        sb_q.push_back(e);
    endtask

    task automatic check_verdict(input string tag, input int lat);
        exp_t e;
        check({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check({tag, "_lat"},     32'(lat),         32'(e.lat));
        check({tag, "_done"},    32'(done),        32'd1);
        check({tag, "_pass"},    32'(pass),        32'(e.p));
        check({tag, "_fail"},    32'(fail),        32'(e.f));
        check({tag, "_timeout"}, 32'(timeout),     32'(e.t));
        check({tag, "_result"},  32'(result),      32'(e.res));
        check({tag, "_wcount"},  32'(write_count), 32'(e.wc));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_result"},  32'(result),      32'd0);
        check({tag, "_wcount"},  32'(write_count), 32'd0);
        check({tag, "_done"},    32'(done),        32'd0);
        check({tag, "_pass"},    32'(pass),        32'd0);
        check({tag, "_fail"},    32'(fail),        32'd0);
        check({tag, "_timeout"}, 32'(timeout),     32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;

        apply_reset(5);
        check_idle("rst");

        // Single passing write
        push_exp(17, 1'b1, 1'b0, 1'b0, 8'h33, 8'd1);
        do_write(16'h0040, 8'h33);
        wait_done(100, n);
        check_verdict("s1", n);

        // Wrong value
        apply_reset(2);
        push_exp(17, 1'b0, 1'b1, 1'b0, 8'h32, 8'd1);
        do_write(16'h0040, 8'h32);
        wait_done(100, n);
        check_verdict("s2", n);

        // Second write restarts the quiet window and overwrites the result
        apply_reset(2);
        do_write(16'h0040, 8'h00);
        repeat (9) tick();
        check("s3_pending", 32'(done), 32'd0);
        push_exp(17, 1'b1, 1'b0, 1'b0, 8'h33, 8'd2);
        do_write(16'h0040, 8'h33);
        wait_done(100, n);
        check_verdict("s3", n);

        // Other-address writes keep SETTLE from ever going quiet
        apply_reset(2);
        push_exp(1001, 1'b0, 1'b0, 1'b1, 8'h33, 8'd1);
        do_write(16'h0040, 8'h33);
        bg_writes(16'h0041, n);
        check_verdict("s4", n);

        // Never a result write; terminal state ignores a late hit
        apply_reset(2);
        push_exp(1001, 1'b0, 1'b0, 1'b1, 8'h00, 8'd0);
        bg_writes(16'h0100, n);
        check_verdict("s5", n);
        do_write(16'h0040, 8'h55);
        repeat (3) tick();
        check("s5_late_done",    32'(done),        32'd1);
        check("s5_late_timeout", 32'(timeout),     32'd1);
        check("s5_late_pass",    32'(pass),        32'd0);
        check("s5_late_result",  32'(result),      32'd0);
        check("s5_late_wcount",  32'(write_count), 32'd0);

        // Reset during SETTLE, then a clean pass
        apply_reset(2);
        do_write(16'h0040, 8'h33);
        repeat (5) tick();
        check("s6_pre_done", 32'(done), 32'd0);
        apply_reset(1);
        check_idle("s6_rst");
        push_exp(17, 1'b1, 1'b0, 1'b0, 8'h33, 8'd1);
        do_write(16'h0040, 8'h33);
        wait_done(100, n);
        check_verdict("s6", n);

        // write_count saturation
        apply_reset(2);
        push_exp(17, 1'b1, 1'b0, 1'b0, 8'h33, 8'hFF);
        repeat (300) do_write(16'h0040, 8'h33);
        check("s7_sat_pending", 32'(write_count), 32'hFF);
        wait_done(100, n);
        check_verdict("s7", n);

        // Verdict and timeout land on the same edge: verdict wins
        apply_reset(2);
        repeat (983) tick();
        push_exp(17, 1'b1, 1'b0, 1'b0, 8'h33, 8'd1);
        do_write(16'h0040, 8'h33);
        wait_done(100, n);
        check_verdict("s8", n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
